// File: rtl/assoc_cache_if.sv
// Processor word port and memory block port of the set-associative cache.
// The cache uses the slave modport; the processor/memory environment uses master.
interface assoc_cache_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with LRU ages and hit/miss counters.
// Hits complete in the cycle presented; misses stall through optional write-back then fill.
module assoc_cache #(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    assoc_cache_if.slave     bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 28 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WBACK, FILL} state_t;
    state_t state, state_nxt;

    logic [WAYS-1:0]  valid    [SETS];
    logic [WAYS-1:0]  dirty    [SETS];
    logic [WAY_W-1:0] age      [SETS][WAYS];
    logic [TAG_W-1:0] tag_arr  [SETS][WAYS];
    logic [127:0]     data_arr [SETS][WAYS];

    logic [IDX_W-1:0] idx, miss_idx, acc_set;
    logic [TAG_W-1:0] tag, miss_tag;
    logic [1:0]       word;
    logic [WAY_W-1:0] hit_way, victim, victim_q, acc_way;
    logic             req, hit, hit_now, miss_det, fill_done, acc_en, miss_pending, found_inv;

    assign idx       = bus.proc_addr[IDX_W+1:2];
    assign tag       = bus.proc_addr[29:IDX_W+2];
    assign word      = bus.proc_addr[1:0];
    assign req       = bus.proc_read | bus.proc_write;
    assign hit_now   = (state == IDLE) && req && hit;
    assign miss_det  = (state == IDLE) && req && !hit;
    assign fill_done = (state == FILL) && bus.mem_ready;
    assign acc_en    = hit_now || fill_done;
    assign acc_set   = fill_done ? miss_idx : idx;
    assign acc_way   = fill_done ? victim_q : hit_way;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tag_arr[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest line is the fallback victim; any empty way takes priority, lowest index first.
    always_comb begin
        victim    = '0;
        found_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!valid[idx][w] && !found_inv) begin
                victim    = WAY_W'(w);
                found_inv = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.proc_stall = 1'b0;
        bus.proc_rdata = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (bus.proc_read && !bus.proc_write)
                            bus.proc_rdata = data_arr[idx][hit_way][{word, 5'd0} +: 32];
                    end else begin
                        bus.proc_stall = 1'b1;
                        state_nxt = (valid[idx][victim] && dirty[idx][victim]) ? WBACK : FILL;
                    end
                end
            end
            WBACK: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = {tag_arr[miss_idx][victim_q], miss_idx};
                bus.mem_wdata  = data_arr[miss_idx][victim_q];
                if (bus.mem_ready) state_nxt = FILL;
            end
            FILL: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_addr   = {miss_tag, miss_idx};
                if (bus.mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Victim and address are captured so a dropped request cannot redirect the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_q     <= '0;
            miss_idx     <= '0;
            miss_tag     <= '0;
            miss_pending <= 1'b0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            if (state == IDLE) miss_pending <= miss_det;
            if (miss_det) begin
                victim_q <= victim;
                miss_idx <= idx;
                miss_tag <= tag;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
            if (hit_now && !miss_pending && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
            end
        end else begin
            if (fill_done) begin
                valid[miss_idx][victim_q] <= 1'b1;
                dirty[miss_idx][victim_q] <= 1'b0;
            end
            if (hit_now && bus.proc_write) dirty[idx][hit_way] <= 1'b1;
            if (acc_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == acc_way)
                        age[acc_set][w] <= '0;
                    else if (age[acc_set][w] < age[acc_set][acc_way])
                        age[acc_set][w] <= age[acc_set][w] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_arr[miss_idx][victim_q] <= bus.mem_rdata;
            tag_arr[miss_idx][victim_q]  <= miss_tag;
        end
        if (hit_now && bus.proc_write)
            data_arr[idx][hit_way][{word, 5'd0} +: 32] <= bus.proc_wdata;
    end
endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative, write-back, write-allocate cache with LRU replacement and hit/miss counters. It is the drop-in successor to the direct-mapped cache placed between the MIPS pipeline and each slow memory, used as both I-cache and D-cache. The processor side keeps the 30-bit word-address, single-word interface. The memory side keeps the 128-bit block interface with ready handshake.

## Interface
- WAYS, 2: associativity; legal values 1, 2, 4.
- SETS, 4: number of sets; power of two, at least 2.
- CNT_W, 16: width of the hit and miss counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- proc_read  in  1  read request; held stable by the processor while proc_stall=1.
- proc_write  in  1  write request; same hold rule. If asserted together with proc_read, the request is treated as a write.
- proc_addr  in  30  word address: [1:0] word in block, [log2(SETS)+1:2] index, remaining upper bits tag.
- proc_wdata  in  32  write data.
- proc_rdata  out  32  read data; valid when proc_read=1 and proc_stall=0.
- proc_stall  out  1  combinational; 1 while a request cannot complete this cycle.
- mem_read  out  1  block read request.
- mem_write  out  1  block write-back request.
- mem_addr  out  28  block address, equal to word address [29:2].
- mem_wdata  out  128  write-back block; word 0 sits in [31:0].
- mem_rdata  in  128  fill block; sampled on the edge where mem_ready=1.
- mem_ready  in  1  one-cycle pulse completing the current memory request.
- hit_cnt  out  CNT_W  saturating count of hits.
- miss_cnt  out  CNT_W  saturating count of misses.

## Operation
- Storage per way per set: valid bit, dirty bit, tag, 128-bit data, and an age field of log2(WAYS) bits (no age field when WAYS=1).
- FSM states: IDLE, WBACK, FILL.
- IDLE with no request:
  - proc_stall=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- IDLE with a request, hit (some valid way in the set has a matching tag):
  - proc_stall=0.
  - Read: proc_rdata returns the selected word combinationally.
  - Write: the word is updated at the clock edge and the line's dirty bit is set to 1.
  - The line's LRU age is updated.
- IDLE with a request, miss:
  - proc_stall=1.
  - Victim selection: the lowest-index invalid way; if none, the way with the maximum age.
  - Next state is WBACK if the victim is valid and dirty, otherwise FILL.
- WBACK:
  - mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block, proc_stall=1.
  - On mem_ready: go to FILL.
- FILL:
  - mem_read=1, mem_addr=proc_addr[29:2], proc_stall=1.
  - On mem_ready: write mem_rdata into the victim way and set valid=1, dirty=0, tag=new tag. Go to IDLE.
- After a fill, the request completes as a hit in the following IDLE cycle; a write sets dirty at that point.
- LRU update on any access to way w (hit or fill completion):
  - Every way whose age is below age[w] increments by 1.
  - age[w] is set to 0.
  - Ages within a set always form a permutation of 0..WAYS-1.
- Counters:
  - miss_cnt increments once, on the IDLE cycle that detects the miss.
  - hit_cnt increments on an IDLE hit, except the completion cycle of a request that just missed (tracked by an internal miss_pending flag).
  - Both counters saturate at 2^CNT_W-1.

## Timing
- Reset (asynchronous, immediate, including mid-miss):
  - State returns to IDLE.
  - All valid, dirty and miss_pending bits are cleared.
  - Age of way i is set to i.
  - hit_cnt=0, miss_cnt=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - proc_rdata=0 while no request is active.
  - Tag and data arrays need no reset.
- Hit: zero-cycle stall; the request completes in the cycle it is presented.
- Clean miss: stall = 1 (IDLE detect) + L_fill cycles, where L_fill counts from mem_read asserting through the mem_ready cycle inclusive. proc_stall drops in the IDLE cycle after the fill edge.
- Dirty miss: stall = 1 + L_wb + L_fill cycles.
- mem_read and mem_write are never both 1.
- mem_read/mem_write deassert in the cycle after mem_ready and stay high continuously until then.
- mem_ready arriving in IDLE is ignored.
- A request dropped while stalled (protocol violation) does not abort the memory transaction; the fill still completes.

## Test plan
- Reset, then read 0x000 -> miss:
  - proc_stall=1, mem_read=1, mem_addr=0.
  - Memory returns 0x...0003_0002_0001_0000 -> proc_rdata=0x0000_0000 on the stall-low cycle; then miss_cnt=1, hit_cnt=0.
  - Read 0x001 next -> 0x0000_0001 with zero stall; hit_cnt=1.
- WAYS=2, SETS=4:
  - Read addresses 0x000 and 0x010 (same set 0) -> two misses, no write-back.
  - Re-read 0x000 -> hit.
  - Read 0x020 -> evicts way holding 0x010 (the LRU line).
- Write 0xDEADBEEF to 0x000 (hit, dirty). Force eviction via 0x010 and 0x020:
  - mem_write=1, mem_addr=0x0000000, mem_wdata[31:0]=0xDEADBEEF.
  - Only after mem_ready does mem_read=1 appear.
- Write miss to 0x005:
  - Fill, then word 1 of the block becomes proc_wdata and dirty=1.
  - Subsequent read of 0x005 returns the written value; the other three words equal memory contents.
- Assert rst_n=0 during FILL:
  - mem_read=0 immediately.
  - Same address afterwards misses again; counters=0.
- CNT_W=4: run 20 hits -> hit_cnt holds at 15.
